// File: rtl/por_readback_seq_if.sv
// POR readback bus: two asynchronous power-good indicators in, pad readback out.
// slave is the sequencer side, master is the environment driving POR and observing pads.
interface por_readback_seq_if;
  logic       por1_i;
  logic       por2_i;
  logic [1:0] status_o;
  logic [3:0] checkbits_o;
  logic       fault_o;
  logic [3:0] drop_cnt_o;

  modport slave (
    input  por1_i,
    input  por2_i,
    output status_o,
    output checkbits_o,
    output fault_o,
    output drop_cnt_o
  );

  modport master (
    output por1_i,
    output por2_i,
    input  status_o,
    input  checkbits_o,
    input  fault_o,
    input  drop_cnt_o
  );
endinterface

// File: rtl/por_readback_seq.sv
// Synchronizes/debounces POR1/POR2 and reports power-up order (POR1 then POR2) on pad readback.
// Optional macro POR_READBACK_STICKY_FAULT_EN makes FAULT absorbing until wb_rst_i.
module por_readback_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  por_readback_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_P1    = 2'd1,
    ST_P12   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       por_raw;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       filt_q,  filt_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_t           state_q, state_d;
  logic [1:0]       status_q, status_d;
  logic [3:0]       chk_q, chk_d;
  logic             fault_q, fault_d;
  logic [3:0]       drop_q, drop_d;

  logic             f1, f2;

  assign por_raw = {bus.por2_i, bus.por1_i};
  assign f1      = filt_q[0];
  assign f2      = filt_q[1];

  // Index 0 is POR1, index 1 is POR2.
  always_comb begin
    sync1_d = por_raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] + CNT_W'(1) == DEB_LIMIT) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (f1)      state_d = ST_P1;
        else if (f2) state_d = ST_FAULT;
      end
      ST_P1: begin
        if (!f1)     state_d = ST_FAULT;
        else if (f2) state_d = ST_P12;
      end
      ST_P12: begin
        if (!f1 || !f2) state_d = ST_FAULT;
      end
      ST_FAULT: begin
`ifdef POR_READBACK_STICKY_FAULT_EN
        state_d = ST_FAULT;
`else
        if (!f1 && !f2) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so they register on the same edge as the state.
  always_comb begin
    status_d = 2'b00;
    chk_d    = 4'h0;
    fault_d  = 1'b0;
    unique case (state_d)
      ST_IDLE:  begin status_d = 2'b00; chk_d = 4'h0; fault_d = 1'b0; end
      ST_P1:    begin status_d = 2'b01; chk_d = 4'h9; fault_d = 1'b0; end
      ST_P12:   begin status_d = 2'b11; chk_d = 4'h5; fault_d = 1'b0; end
      ST_FAULT: begin status_d = 2'b10; chk_d = 4'hA; fault_d = 1'b1; end
      default:  begin status_d = 2'b00; chk_d = 4'h0; fault_d = 1'b0; end
    endcase

    drop_d = drop_q;
    if (state_d == ST_FAULT && state_q != ST_FAULT && drop_q != 4'hF) begin
      drop_d = drop_q + 4'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      state_q  <= ST_IDLE;
      status_q <= 2'b00;
      chk_q    <= 4'h0;
      fault_q  <= 1'b0;
      drop_q   <= 4'h0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      state_q  <= state_d;
      status_q <= status_d;
      chk_q    <= chk_d;
      fault_q  <= fault_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.status_o    = status_q;
  assign bus.checkbits_o = chk_q;
  assign bus.fault_o     = fault_q;
  assign bus.drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_por_readback_seq.sv
// Directed vector bench for por_readback_seq; inputs change and outputs are sampled on negedge.
module tb_por_readback_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  por_readback_seq_if bus ();

  por_readback_seq #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef POR_READBACK_STICKY_FAULT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       p1;
    logic       p2;
    int         edges;
    logic [1:0] st;
    logic [3:0] ck;
    logic       flt;
    logic [3:0] drp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [1:0] es, input logic [3:0] ec,
                       input logic ef, input logic [3:0] ed);
    total++;
    if ({bus.status_o, bus.checkbits_o, bus.fault_o, bus.drop_cnt_o} !== {es, ec, ef, ed}) begin
      bad++;
      $display("FAIL %s: got status=%b chk=%h fault=%b drop=%h, want status=%b chk=%h fault=%b drop=%h",
               name, bus.status_o, bus.checkbits_o, bus.fault_o, bus.drop_cnt_o, es, ec, ef, ed);
    end
  endtask

  task automatic drive(input logic p1, input logic p2, input int edges);
    bus.por1_i = p1;
    bus.por2_i = p2;
    repeat (edges) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected values after recovery differ between sticky and recovering builds.
  function automatic vec_t mk(input string n, input logic p1, input logic p2, input int e,
                              input logic [1:0] st, input logic [3:0] ck, input logic f,
                              input logic [3:0] d);
    vec_t v;
    v.name = n; v.p1 = p1; v.p2 = p2; v.edges = e;
    v.st = st; v.ck = ck; v.flt = f; v.drp = d;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.por1_i = 1'b0;
    bus.por2_i = 1'b0;

    vecs.push_back(mk("p1_pre",      1, 0, 18,  2'b00, 4'h0, 0, 4'h0));
    vecs.push_back(mk("p1_edge19",   1, 0, 1,   2'b01, 4'h9, 0, 4'h0));
    vecs.push_back(mk("p1_hold",     1, 0, 181, 2'b01, 4'h9, 0, 4'h0));
    vecs.push_back(mk("p2_pre",      1, 1, 18,  2'b01, 4'h9, 0, 4'h0));
    vecs.push_back(mk("p12_edge19",  1, 1, 1,   2'b11, 4'h5, 0, 4'h0));
    vecs.push_back(mk("p2_drop",     1, 0, 19,  2'b10, 4'hA, 1, 4'h1));
    if (STICKY) begin
      vecs.push_back(mk("recover",     0, 0, 19, 2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("glitch_hi",   1, 0, 10, 2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("glitch_lo",   0, 0, 30, 2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("restart_a",   1, 0, 15, 2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("restart_gap", 0, 0, 2,  2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("restart_b",   1, 0, 15, 2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("restart_lo",  0, 0, 30, 2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("order_pre",   0, 1, 18, 2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("order_fault", 0, 1, 1,  2'b10, 4'hA, 1, 4'h1));
      vecs.push_back(mk("order_recov", 0, 0, 19, 2'b10, 4'hA, 1, 4'h1));
    end else begin
      vecs.push_back(mk("recover",     0, 0, 19, 2'b00, 4'h0, 0, 4'h1));
      vecs.push_back(mk("glitch_hi",   1, 0, 10, 2'b00, 4'h0, 0, 4'h1));
      vecs.push_back(mk("glitch_lo",   0, 0, 30, 2'b00, 4'h0, 0, 4'h1));
      vecs.push_back(mk("restart_a",   1, 0, 15, 2'b00, 4'h0, 0, 4'h1));
      vecs.push_back(mk("restart_gap", 0, 0, 2,  2'b00, 4'h0, 0, 4'h1));
      vecs.push_back(mk("restart_b",   1, 0, 15, 2'b00, 4'h0, 0, 4'h1));
      vecs.push_back(mk("restart_lo",  0, 0, 30, 2'b00, 4'h0, 0, 4'h1));
      vecs.push_back(mk("order_pre",   0, 1, 18, 2'b00, 4'h0, 0, 4'h1));
      vecs.push_back(mk("order_fault", 0, 1, 1,  2'b10, 4'hA, 1, 4'h2));
      vecs.push_back(mk("order_recov", 0, 0, 19, 2'b00, 4'h0, 0, 4'h2));
    end

    #1;
    check("reset_state", 2'b00, 4'h0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].p1, vecs[i].p2, vecs[i].edges);
      check(vecs[i].name, vecs[i].st, vecs[i].ck, vecs[i].flt, vecs[i].drp);
    end

    // Repeated drop-out: recovering build re-sequences and saturates the counter.
    drive(1'b0, 1'b0, 1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
`ifdef POR_READBACK_STICKY_FAULT_EN
      drive(1'b1, 1'b0, 20);
      drive(1'b1, 1'b1, 20);
      drive(1'b1, 1'b0, 20);
      drive(1'b0, 1'b0, 20);
      check($sformatf("sticky_iter%0d", i), 2'b10, 4'hA, 1'b1, 4'h1);
`else
      drive(1'b1, 1'b0, 20);
      check($sformatf("loop_p1_%0d", i), 2'b01, 4'h9, 1'b0, (i > 15) ? 4'hF : 4'(i));
      drive(1'b1, 1'b1, 20);
      check($sformatf("loop_p12_%0d", i), 2'b11, 4'h5, 1'b0, (i > 15) ? 4'hF : 4'(i));
      drive(1'b1, 1'b0, 20);
      check($sformatf("loop_fault_%0d", i), 2'b10, 4'hA, 1'b1, (i + 1 > 15) ? 4'hF : 4'(i + 1));
      drive(1'b0, 1'b0, 20);
      check($sformatf("loop_idle_%0d", i), 2'b00, 4'h0, 1'b0, (i + 1 > 15) ? 4'hF : 4'(i + 1));
`endif
    end

    // Asynchronous reset from P12, then release with both POR inputs already high.
    do_reset();
    drive(1'b1, 1'b0, 20);
    drive(1'b1, 1'b1, 20);
    check("pre_async_p12", 2'b11, 4'h5, 1'b0, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_now", 2'b00, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    check("async_rst_held", 2'b00, 4'h0, 1'b0, 4'h0);
    rst = 1'b0;
    repeat (18) @(negedge clk);
    check("both_hi_edge18", 2'b00, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    check("both_hi_edge19", 2'b01, 4'h9, 1'b0, 4'h0);
    @(negedge clk);
    check("both_hi_edge20", 2'b11, 4'h5, 1'b0, 4'h0);
    repeat (50) @(negedge clk);
    check("both_hi_settled", 2'b11, 4'h5, 1'b0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/por_readback_seq.md
# por_readback_seq

Digital readback sequencer in the user project area that consumes the two power-on-reset indicators and reports power-up progress on user GPIOs. It sits directly upstream of the mprj_io pads that carry the 2-bit status and 4-bit checkbits readback. It synchronizes and debounces both POR indicators and tracks the required power-up order (POR1 then POR2) with a small state machine. It also flags and counts ordering or drop-out faults.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before a filtered POR level changes; legal range 1..2^CNT_W-1.
- CNT_W, 5: width of each debounce counter.
- wb_clk_i  in  1  user project clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- por1_i  in  1  POR1 good indicator, asynchronous to wb_clk_i, high = power good.
- por2_i  in  1  POR2 good indicator, asynchronous, high = power good.
- status_o  out  2  readback status {hi, lo} to pads.
- checkbits_o  out  4  readback check pattern to pads.
- fault_o  out  1  high while the FSM is in FAULT.
- drop_cnt_o  out  4  saturating count of FAULT entries.

## Operation
- Each POR input passes through a 2-flop synchronizer, then a debounce filter. The filter keeps a filtered level f and a counter.
  - Counter clears whenever sync == f.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, f takes the sync value and the counter clears.
- The FSM advances at most one state per cycle. States and outputs (status_o / checkbits_o / fault_o):
  - IDLE: 2'b00 / 4'h0 / 0.
  - P1: 2'b01 / 4'h9 / 0.
  - P12: 2'b11 / 4'h5 / 0.
  - FAULT: 2'b10 / 4'hA / 1.
- IDLE transitions:
  - f1=1 → P1, regardless of f2.
  - f1=0 and f2=1 → FAULT (ordering violation).
- P1 transitions:
  - f1=0 → FAULT. This has priority over f2.
  - f2=1 → P12.
- P12 transition: f1=0 or f2=0 → FAULT.
- FAULT exit depends on configuration; see Configuration.
- f1 and f2 both rising in the same cycle from IDLE: P1 on the next edge, P12 on the edge after.
- drop_cnt_o increments by 1 on every transition into FAULT and saturates at 4'hF, with no wrap.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state register.
- Reset value of every output is 0; state resets to IDLE.

## Timing
- Input edge to filtered level change: sync takes 2 edges plus DEBOUNCE_CYCLES edges, i.e. 2+DEBOUNCE_CYCLES edges.
- Filtered change to state/outputs update: 1 edge. Total is 3+DEBOUNCE_CYCLES edges; with the default that is 19 cycles.
- Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is rejected; the counter restarts from 0 on each reversion.
- Reset assertion mid-sequence has immediate effect:
  - Outputs clear, FSM returns to IDLE, counters, filters and synchronizers clear, and drop_cnt_o clears.
- After reset deassertion, no state change occurs before 3+DEBOUNCE_CYCLES edges, even if both POR inputs are already high.

## Configuration
- POR_READBACK_STICKY_FAULT_EN defined:
  - FAULT is absorbing; only wb_rst_i leaves it.
- Not defined:
  - FAULT → IDLE on the first edge where f1=0 and f2=0, after which normal sequencing resumes.
  - drop_cnt_o keeps accumulating across recoveries.

## Test plan
- Default parameters, por1_i rises, then 200 cycles later por2_i rises:
  - status_o goes 00→01 with checkbits_o=4'h9, 19 cycles after por1_i.
  - Then 01→11 with checkbits_o=4'h5, 19 cycles after por2_i.
  - fault_o stays 0.
- por1_i high pulse of 10 cycles, then low:
  - Outputs remain 00/0 throughout (glitch rejected).
- por2_i rises before por1_i:
  - After 19 cycles status_o=10, checkbits_o=4'hA, fault_o=1, drop_cnt_o=1.
- From P12, por2_i drops, then both drop, then sequence repeats, 16 times in total:
  - Without the macro: returns to IDLE each time and re-sequences, drop_cnt_o saturates at 4'hF.
  - With the macro: stays in FAULT after the first drop with drop_cnt_o=1.
- Both POR inputs tied high at reset release:
  - 01/9 at edge 19, 11/5 at edge 20, never FAULT.
- wb_rst_i asserted asynchronously while in P12:
  - All outputs 0 immediately without waiting for a clock edge.
  - After release, the sequence restarts from IDLE with the full 19-cycle latency.
